// File: rtl/compare_branch_unit.sv
// Branch-resolution stage: registered operands -> 18-bit comparator -> branch decision -> held result.
// Optional build macro SIGNED_CMP_EN selects a two's-complement compare (default: unsigned).
`timescale 1ns/1ps

module EighteenBitComparator (
  input  logic [17:0] i_a,
  input  logic [17:0] i_b,
  output logic        o_equal,
  output logic        o_a_greater,
  output logic        o_a_less
);
  assign o_equal     = (i_a == i_b);
  assign o_a_greater = (i_a >  i_b);
  assign o_a_less    = (i_a <  i_b);
endmodule

module compare_branch_unit #(
  parameter int DATA_W = 18,
  parameter int PC_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [2:0]        cond,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   offset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [PC_W-1:0]   next_pc,
  output logic [2:0]        flags
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMP     = 2'd1,
    S_RESOLVE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [2:0]        r_cond;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_offset;
  logic [2:0]        r_flags;
  logic              r_taken;
  logic [PC_W-1:0]   r_next_pc;

  logic [DATA_W-1:0] w_cmp_a;
  logic [DATA_W-1:0] w_cmp_b;
  logic              w_equal;
  logic              w_a_greater;
  logic              w_a_less;
  logic              w_taken;
  logic [PC_W-1:0]   w_next_pc;

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign w_cmp_a = {~r_op_a[DATA_W-1], r_op_a[DATA_W-2:0]};
  assign w_cmp_b = {~r_op_b[DATA_W-1], r_op_b[DATA_W-2:0]};
`else
  assign w_cmp_a = r_op_a;
  assign w_cmp_b = r_op_b;
`endif

  EighteenBitComparator u_cmp (
    .i_a         (w_cmp_a),
    .i_b         (w_cmp_b),
    .o_equal     (w_equal),
    .o_a_greater (w_a_greater),
    .o_a_less    (w_a_less)
  );

  // r_flags = {A_less, equal, A_greater}
  always_comb begin
    w_taken = 1'b0;
    case (r_cond)
      3'b000:  w_taken = r_flags[1];
      3'b001:  w_taken = ~r_flags[1];
      3'b010:  w_taken = r_flags[2];
      3'b011:  w_taken = r_flags[0];
      3'b100:  w_taken = r_flags[2] | r_flags[1];
      3'b101:  w_taken = r_flags[0] | r_flags[1];
      3'b110:  w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_next_pc = r_pc + (w_taken ? r_offset : PC_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_state_nxt = S_CMP;
      S_CMP:     w_state_nxt = S_RESOLVE;
      S_RESOLVE: w_state_nxt = S_HOLD;
      S_HOLD:    if (out_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_cond    <= '0;
      r_pc      <= '0;
      r_offset  <= '0;
      r_flags   <= '0;
      r_taken   <= 1'b0;
      r_next_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && in_valid) begin
        r_op_a   <= op_a;
        r_op_b   <= op_b;
        r_cond   <= cond;
        r_pc     <= pc;
        r_offset <= offset;
      end
      if (r_state == S_CMP) begin
        r_flags <= {w_a_less, w_equal, w_a_greater};
      end
      if (r_state == S_RESOLVE) begin
        r_taken   <= w_taken;
        r_next_pc <= w_next_pc;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_HOLD);
  assign taken     = r_taken;
  assign next_pc   = r_next_pc;
  assign flags     = r_flags;

endmodule

// File: tb/tb_compare_branch_unit.sv
// Scoreboarded bench for compare_branch_unit: directed vectors, backpressure, mid-op reset, random traffic.
`timescale 1ns/1ps

module tb_compare_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] op_a = '0;
  logic [17:0] op_b = '0;
  logic [2:0]  cond = '0;
  logic [9:0]  pc = '0;
  logic [9:0]  offset = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        taken;
  logic [9:0]  next_pc;
  logic [2:0]  flags;

  typedef struct packed {
    logic       taken;
    logic [9:0] npc;
    logic [2:0] flags;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   rnd_rdy = 1'b0;
  bit   hold_prev = 1'b0;

  compare_branch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cond      (cond),
    .pc        (pc),
    .offset    (offset),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .next_pc   (next_pc),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: compare as integers, then apply the condition table and PC arithmetic.
  function automatic res_t model(input logic [17:0] a, input logic [17:0] b,
                                 input logic [2:0] c, input logic [9:0] p, input logic [9:0] o);
    int   sa;
    int   sb;
    bit   lt;
    bit   eq;
    bit   gt;
    bit   tk;
    res_t r;
`ifdef SIGNED_CMP_EN
    sa = a[17] ? int'(a) - 262144 : int'(a);
    sb = b[17] ? int'(b) - 262144 : int'(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    lt = (sa < sb);
    eq = (sa == sb);
    gt = (sa > sb);
    case (c)
      3'd0: tk = eq;
      3'd1: tk = !eq;
      3'd2: tk = lt;
      3'd3: tk = gt;
      3'd4: tk = lt || eq;
      3'd5: tk = gt || eq;
      3'd6: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    r.taken = tk;
    r.npc   = 10'((int'(p) + (tk ? int'(o) : 1)) % 1024);
    r.flags = {lt, eq, gt};
    return r;
  endfunction

  // Monitor: whenever a result is presented it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("hold_valid", {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got taken=%0b next_pc=%0h with empty queue", taken, next_pc);
          hold_prev = 1'b0;
        end else begin
          chk("taken",   {31'd0, taken},   {31'd0, exp_q[0].taken});
          chk("next_pc", {22'd0, next_pc}, {22'd0, exp_q[0].npc});
          chk("flags",   {29'd0, flags},   {29'd0, exp_q[0].flags});
          if (out_ready) begin
            void'(exp_q.pop_front());
            hold_prev = 1'b0;
          end else begin
            hold_prev = 1'b1;
          end
        end
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called and returns at posedge+1.
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [2:0] c,
                      input logic [9:0] p, input logic [9:0] o, input bit lat);
    int w;
    w = 0;
    while (!in_ready && w < 64) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      return;
    end
    op_a = a; op_b = b; cond = c; pc = p; offset = o;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b, c, p, o));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (lat) begin
      chk("lat_edge1", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("lat_edge2", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("lat_edge3", {31'd0, out_valid}, 32'd1);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !in_ready) && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_queue", exp_q.size(), 32'd0);
  endtask

  function automatic logic [17:0] pick();
    case ($urandom_range(0, 5))
      0: return 18'h00000;
      1: return 18'h3FFFF;
      2: return 18'h20000;
      3: return 18'h1FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] ra;
    logic [17:0] rb;
    #12;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_taken",     {31'd0, taken},     32'd0);
    chk("rst_next_pc",   {22'd0, next_pc},   32'd0);
    chk("rst_flags",     {29'd0, flags},     32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(18'h2A5A5, 18'h2A5A5, 3'b000, 10'h010, 10'h004, 1'b1);
    send(18'h00001, 18'h3FFFF, 3'b010, 10'h3FF, 10'h3FE, 1'b1);
    drain();

    // Backpressure: result must hold while a competing request is presented.
    out_ready = 1'b0;
    send(18'h00010, 18'h00020, 3'b100, 10'h200, 10'h3F0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op_a = 18'h3FFFF; op_b = 18'h0; cond = 3'b110; pc = 10'h055; offset = 10'h011;
      @(posedge clk);
      #1;
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset while the request sits in RESOLVE.
    out_ready = 1'b0;
    send(18'h00100, 18'h00100, 3'b000, 10'h123, 10'h001, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_taken",     {31'd0, taken},     32'd0);
    chk("mid_rst_flags",     {29'd0, flags},     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(18'd5, 18'd3, 3'b001, 10'h040, 10'h008, 1'b1);
    drain();

    for (int c = 0; c < 8; c++) begin
      send(18'd7, 18'd9, 3'(c), 10'h100, 10'h010, 1'b0);
    end
    drain();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      ra = pick();
      rb = ($urandom_range(0, 4) == 0) ? ra : pick();
      send(ra, rb, 3'($urandom), 10'($urandom), 10'($urandom), 1'b0);
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
